serial_addsub_seq: RTL

Bit-serial add/subtract sequencer. It time-shares a single `FullAdder` instance to compute a WIDTH-bit sum or difference, one bit per clock, LSB first. It sits between a requesting controller (Start/Done handshake) and the shared one-bit adder datapath, in area-constrained builds where a ripple-carry array is too large. It owns the operand shift registers, the carry flip-flop, the bit counter and the flag logic.

---
 rtl/serial_addsub_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/serial_addsub_seq.sv
// ---------------------------------------------------------------------------
// serial_addsub_seq
// Bit-serial add/subtract sequencer. A single one-bit FullAdder is time-shared
// to produce a WIDTH-bit sum or difference, one bit per clock, LSB first.
//
// Ports
//   Clk       in   1      clock, rising edge
//   Rst_n     in   1      synchronous active-low reset
//   Start     in   1      request; accepted only in IDLE or DONE
//   Sub       in   1      0 = A+B, 1 = A-B (sampled with Start)
//   A, B      in   WIDTH  operands (sampled with Start)
//   Busy      out  1      high while the operation is running
//   Done      out  1      one-cycle pulse; Result and flags valid
//   Result    out  WIDTH  sum/difference, held until next accepted Start
//   Cout      out  1      final carry out (for Sub: 1 = no borrow)
//   Overflow  out  1      two's-complement signed overflow
//   Zero      out  1      Result == 0
// ---------------------------------------------------------------------------

// One-bit full adder shared by every bit position.
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Out,
  output logic Cout
);
  assign Out  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_addsub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_M1   = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;
  logic             r_sub;
  logic             r_carry;
  logic             r_c_msb;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;

  logic             w_accept;
  logic             w_running;
  logic             w_last;
  logic             w_fa_b;
  logic             w_fa_out;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_result_next;

  // Start is only honoured when no operation is in flight.
  assign w_accept  = Start && (r_state != S_RUN);
  assign w_running = (r_state == S_RUN);
  assign w_last    = w_running && (r_count == LAST_BIT);

  // Subtraction is A + ~B + 1: invert B per bit, the +1 comes from the
  // carry flop being preloaded with Sub.
  assign w_fa_b = r_op_b[0] ^ r_sub;

  FullAdder u_fa (
    .A    (r_op_a[0]),
    .B    (w_fa_b),
    .Cin  (r_carry),
    .Out  (w_fa_out),
    .Cout (w_fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands
  // at position 0.
  assign w_result_next = {w_fa_out, r_result[WIDTH-1:1]};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_next = S_RUN;
      S_RUN:   if (r_count == LAST_BIT) w_state_next = S_DONE;
      S_DONE:  w_state_next = Start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (r_state)
      S_RUN:   Busy = 1'b1;
      S_DONE:  Done = 1'b1;
      default: begin
        Busy = 1'b0;
        Done = 1'b0;
      end
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
      r_count    <= '0;
      r_sub      <= 1'b0;
      r_carry    <= 1'b0;
      r_c_msb    <= 1'b0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_accept) begin
      r_op_a   <= A;
      r_op_b   <= B;
      r_sub    <= Sub;
      r_carry  <= Sub;
      r_count  <= '0;
      r_result <= '0;
    end else if (w_running) begin
      r_result <= w_result_next;
      r_op_a   <= {1'b0, r_op_a[WIDTH-1:1]};
      r_op_b   <= {1'b0, r_op_b[WIDTH-1:1]};
      r_carry  <= w_fa_cout;
      r_count  <= r_count + CW'(1);
      // Carry leaving bit WIDTH-2 is the carry into the MSB.
      if (r_count == MSB_M1) begin
        r_c_msb <= w_fa_cout;
      end
      // Flags change only when the final bit is produced.
      if (w_last) begin
        r_cout     <= w_fa_cout;
        r_overflow <= w_fa_cout ^ r_c_msb;
        r_zero     <= (w_result_next == '0);
      end
    end
  end

  assign Result   = r_result;
  assign Cout     = r_cout;
  assign Overflow = r_overflow;
  assign Zero     = r_zero;

endmodule
